// File: rtl/fft_pkg.sv
// Shared constants, Q1.14 twiddle table and complex-sample helpers for the
// 16-point DFT datapath.
package fft_pkg;

    localparam int SAMPLE_W = 17;
    localparam int CPLX_W   = 34;
    localparam int N        = 16;

    localparam int TW_W     = 16;
    localparam int TW_FRAC  = 14;
    localparam int S1_W     = SAMPLE_W + 2;
    localparam int TW_OUT_W = S1_W + 1;
    localparam int S2_W     = TW_OUT_W + 2;
    localparam int SCALE_SH = 4;
    localparam int PROD_W   = TW_OUT_W + TW_FRAC;

    // W16^m = TW_COS[m] - j*TW_SIN[m], both scaled by 2^14
    localparam logic signed [TW_W-1:0] TW_COS [N] = '{
        16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
       -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270,
        16'sd0,      16'sd6270,   16'sd11585,  16'sd15137
    };
    localparam logic signed [TW_W-1:0] TW_SIN [N] = '{
        16'sd0,      16'sd6270,   16'sd11585,  16'sd15137,
        16'sd16384,  16'sd15137,  16'sd11585,  16'sd6270,
        16'sd0,     -16'sd6270,  -16'sd11585, -16'sd15137,
       -16'sd16384, -16'sd15137, -16'sd11585, -16'sd6270
    };

    function automatic logic signed [SAMPLE_W-1:0] cplx_re(input logic [CPLX_W-1:0] c);
        return c[CPLX_W-1:SAMPLE_W];
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] cplx_im(input logic [CPLX_W-1:0] c);
        return c[SAMPLE_W-1:0];
    endfunction

    function automatic logic [CPLX_W-1:0] cplx_pack(input logic signed [SAMPLE_W-1:0] re,
                                                    input logic signed [SAMPLE_W-1:0] im);
        return {re, im};
    endfunction

    // Clamp an 18-bit signed value into the 17-bit sample range.
    function automatic logic signed [SAMPLE_W-1:0] sat_sample(input logic [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1])
            return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/radix4_bf.sv
// Combinational 4-point complex DFT: X[k] = sum a[n] * (-j)^(nk).
// Uses only add/subtract and re/im swaps, so it is exact and grows 2 bits.
module radix4_bf #(
    parameter int IW = 17
) (
    input  logic [3:0][IW-1:0] in_re,
    input  logic [3:0][IW-1:0] in_im,
    output logic [3:0][IW+1:0] out_re,
    output logic [3:0][IW+1:0] out_im
);

    logic signed [IW+1:0] r  [4];
    logic signed [IW+1:0] im [4];

    for (genvar n = 0; n < 4; n++) begin : g_ext
        assign r[n]  = {{2{in_re[n][IW-1]}}, in_re[n]};
        assign im[n] = {{2{in_im[n][IW-1]}}, in_im[n]};
    end

    assign out_re[0] = r[0]  + r[1]  + r[2]  + r[3];
    assign out_im[0] = im[0] + im[1] + im[2] + im[3];

    // -j*a1 and +j*a3 become re/im swaps with sign flips
    assign out_re[1] = r[0]  + im[1] - r[2]  - im[3];
    assign out_im[1] = im[0] - r[1]  - im[2] + r[3];

    assign out_re[2] = r[0]  - r[1]  + r[2]  - r[3];
    assign out_im[2] = im[0] - im[1] + im[2] - im[3];

    assign out_re[3] = r[0]  - im[1] - r[2]  + im[3];
    assign out_im[3] = im[0] + r[1]  - im[2] - r[3];

endmodule

// File: rtl/butterfly_16.sv
// 16-point complex DFT as 4x4 radix-4 with twiddles, scaled by 1/16,
// two register stages, one frame per clock.
module butterfly_16
    import fft_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [N*CPLX_W-1:0] butterfly_in,
    output logic                out_valid,
    output logic [N*CPLX_W-1:0] butterfly_out
);

    // Handshake: in_valid marks a frame on butterfly_in for that cycle; there is
    // no ready, every marked frame is taken and out_valid echoes it 2 cycles later.

    logic [3:0][3:0][SAMPLE_W-1:0] s1_re, s1_im;  // [n2][n1]
    logic [3:0][3:0][S1_W-1:0]     y_re,  y_im;   // [n2][k1]
    logic [3:0][3:0][TW_OUT_W-1:0] z_re,  z_im;   // [n2][k1]
    logic [3:0][3:0][TW_OUT_W-1:0] a_re,  a_im;   // register A, [n2][k1]
    logic [3:0][3:0][TW_OUT_W-1:0] s2_re, s2_im;  // [k1][n2]
    logic [3:0][3:0][S2_W-1:0]     x_re,  x_im;   // [k1][k2], bin k1+4*k2
    logic [N*CPLX_W-1:0]           b_next;
    logic                          valid_a;

    for (genvar n = 0; n < N; n++) begin : g_unpack
        assign s1_re[n % 4][n / 4] = cplx_re(butterfly_in[n*CPLX_W +: CPLX_W]);
        assign s1_im[n % 4][n / 4] = cplx_im(butterfly_in[n*CPLX_W +: CPLX_W]);
    end

    for (genvar g = 0; g < 4; g++) begin : g_stage1
        radix4_bf #(.IW(SAMPLE_W)) u_bf (
            .in_re  (s1_re[g]),
            .in_im  (s1_im[g]),
            .out_re (y_re[g]),
            .out_im (y_im[g])
        );
    end

    for (genvar n2 = 0; n2 < 4; n2++) begin : g_tw_n2
        for (genvar k1 = 0; k1 < 4; k1++) begin : g_tw_k1
            localparam int M = n2 * k1;
            logic signed [TW_OUT_W-1:0] yr, yi;
            assign yr = {y_re[n2][k1][S1_W-1], y_re[n2][k1]};
            assign yi = {y_im[n2][k1][S1_W-1], y_im[n2][k1]};

            if (M == 0) begin : g_bypass
                assign z_re[n2][k1] = yr;
                assign z_im[n2][k1] = yi;
            end else if (M == 4) begin : g_neg_j
                assign z_re[n2][k1] = yi;
                assign z_im[n2][k1] = -yr;
            end else begin : g_mult
                localparam logic signed [PROD_W-1:0] WC  = PROD_W'(TW_COS[M]);
                localparam logic signed [PROD_W-1:0] WS  = PROD_W'(TW_SIN[M]);
                localparam logic signed [PROD_W-1:0] RND = PROD_W'(1 << (TW_FRAC - 1));
                logic signed [PROD_W-1:0] yr_w, yi_w, pr, pi;
                logic [TW_FRAC-1:0] unused_re_frac, unused_im_frac;
                assign yr_w = PROD_W'(yr);
                assign yi_w = PROD_W'(yi);
                // (yr + j*yi) * (c - j*s), rounded half-up before dropping the fraction
                assign pr = yr_w * WC + yi_w * WS + RND;
                assign pi = yi_w * WC - yr_w * WS + RND;
                assign {z_re[n2][k1], unused_re_frac} = pr;
                assign {z_im[n2][k1], unused_im_frac} = pi;
            end

            assign s2_re[k1][n2] = a_re[n2][k1];
            assign s2_im[k1][n2] = a_im[n2][k1];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_stage2
        radix4_bf #(.IW(TW_OUT_W)) u_bf (
            .in_re  (s2_re[g]),
            .in_im  (s2_im[g]),
            .out_re (x_re[g]),
            .out_im (x_im[g])
        );
    end

    for (genvar k1 = 0; k1 < 4; k1++) begin : g_out_k1
        for (genvar k2 = 0; k2 < 4; k2++) begin : g_out_k2
            localparam int K = k1 + 4 * k2;
            logic [S2_W-SCALE_SH-1:0] re_s, im_s;
            logic [SCALE_SH-1:0]      unused_re_lsb, unused_im_lsb;
            assign {re_s, unused_re_lsb} = x_re[k1][k2];
            assign {im_s, unused_im_lsb} = x_im[k1][k2];
            assign b_next[K*CPLX_W +: CPLX_W] = cplx_pack(sat_sample(re_s), sat_sample(im_s));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_re          <= '0;
            a_im          <= '0;
            valid_a       <= 1'b0;
            butterfly_out <= '0;
            out_valid     <= 1'b0;
        end else begin
            a_re          <= z_re;
            a_im          <= z_im;
            valid_a       <= in_valid;
            butterfly_out <= b_next;
            out_valid     <= valid_a;
        end
    end

endmodule

// File: tb/tb_butterfly_16.sv
// Bench for butterfly_16: directed frames plus random traffic, checked against
// a floating-point DFT reference with a 2-cycle expected-output queue.
module tb_butterfly_16;

    localparam int  NB = 16;
    localparam int  W  = 544;
    localparam real PI = 3.14159265358979323846;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] butterfly_in;
    logic         out_valid;
    logic [W-1:0] butterfly_out;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int rst_cyc = -100;
    int cur_mode = 0;
    bit started = 1'b0;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           mode_q[$];

    butterfly_16 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .butterfly_in  (butterfly_in),
        .out_valid     (out_valid),
        .butterfly_out (butterfly_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        total++;
        if (got - exp > tol || exp - got > tol) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d tol=%0d", tag, got, exp, tol);
        end
    endtask

    function automatic int s_re(input logic [W-1:0] f, input int n);
        logic signed [16:0] v;
        v = f[n*34+17 +: 17];
        return int'(v);
    endfunction

    function automatic int s_im(input logic [W-1:0] f, input int n);
        logic signed [16:0] v;
        v = f[n*34 +: 17];
        return int'(v);
    endfunction

    function automatic logic [W-1:0] put(input logic [W-1:0] f, input int n, input int re, input int im);
        logic [16:0] r;
        logic [16:0] i;
        r = re[16:0];
        i = im[16:0];
        f[n*34 +: 34] = {r, i};
        return f;
    endfunction

    function automatic int rnd_sample();
        return int'($urandom_range(0, 131071)) - 65536;
    endfunction

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] f;
        f = '0;
        for (int n = 0; n < NB; n++) f = put(f, n, rnd_sample(), rnd_sample());
        return f;
    endfunction

    function automatic int sat17(input int v);
        if (v > 65535) return 65535;
        if (v < -65536) return -65536;
        return v;
    endfunction

    // Ideal DFT bin k, divided by 16, floored and clamped.
    task automatic model_bin(input logic [W-1:0] f, input int k, output int er, output int ei, output int tol);
        real sr, si, c, s, ang;
        int  m, xr, xi;
        bit  odd_used;
        sr = 0.0; si = 0.0; odd_used = 1'b0;
        for (int n = 0; n < NB; n++) begin
            xr = s_re(f, n);
            xi = s_im(f, n);
            m  = (n * k) % 16;
            if (m % 4 == 0) begin
                c = (m == 0) ? 1.0 : (m == 8) ? -1.0 : 0.0;
                s = (m == 4) ? 1.0 : (m == 12) ? -1.0 : 0.0;
            end else begin
                ang = 2.0 * PI * m / 16.0;
                c = $cos(ang);
                s = $sin(ang);
            end
            sr = sr + xr * c + xi * s;
            si = si + xi * c - xr * s;
            if (n % 4 != 0 && (xr != 0 || xi != 0)) odd_used = 1'b1;
        end
        er  = sat17($rtoi($floor(sr / 16.0 + 1.0e-6)));
        ei  = sat17($rtoi($floor(si / 16.0 + 1.0e-6)));
        tol = (k % 4 == 0 || !odd_used) ? 0 : 1;
    endtask

    task automatic compare_frame(input logic [W-1:0] f, input int mode);
        int er, ei, tol, gr, gi;
        for (int k = 0; k < NB; k++) begin
            model_bin(f, k, er, ei, tol);
            gr = s_re(butterfly_out, k);
            gi = s_im(butterfly_out, k);
            if (mode == 1) begin
                if (k == 2) check("sat_x2_re", gr, 65535);
                if (tol != 0) continue;
            end
            check($sformatf("bin%0d_re", k), gr, er, tol);
            check($sformatf("bin%0d_im", k), gi, ei, tol);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            exp_q.delete();
            due_q.delete();
            mode_q.delete();
            rst_cyc = cyc;
            started = 1'b1;
        end else if (in_valid) begin
            exp_q.push_back(butterfly_in);
            due_q.push_back(cyc + 1);
            mode_q.push_back(cur_mode);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (rst_cyc == cyc) begin
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_out_ones", $countones(butterfly_out), 0);
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                check("out_valid", int'(out_valid), 1);
                compare_frame(exp_q.pop_front(), mode_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                check("idle_valid", int'(out_valid), 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [W-1:0] f, input int mode);
        @(negedge clk);
        in_valid     = 1'b1;
        butterfly_in = f;
        cur_mode     = mode;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid     = 1'b0;
            butterfly_in = rand_frame();
            cur_mode     = 0;
        end
    endtask

    initial begin
        logic [W-1:0] f;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        butterfly_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // DC
        f = '0;
        for (int n = 0; n < NB; n++) f = put(f, n, 100, 0);
        send(f, 0);
        idle(3);

        // impulse at n = 0, n = 4 (trivial twiddles), n = 1 (non-trivial)
        f = put('0, 0, 1600, 0);
        send(f, 0);
        f = put('0, 4, 1600, 0);
        send(f, 0);
        f = put('0, 1, 1600, 0);
        send(f, 0);
        idle(2);

        // saturation pattern followed by 16 back-to-back random frames
        f = '0;
        for (int n = 0; n < NB; n++)
            f = put(f, n, ((n % 8) inside {0, 1, 2, 6, 7}) ? 65535 : -65536,
                          ((n % 8) <= 4) ? 65535 : -65536);
        send(f, 1);
        for (int i = 0; i < 16; i++) send(rand_frame(), 0);

        // random frames with random gaps
        for (int i = 0; i < 6; i++) begin
            send(rand_frame(), 0);
            idle(int'($urandom_range(0, 2)));
        end

        // reset mid-stream drops in-flight frames
        for (int i = 0; i < 3; i++) send(rand_frame(), 0);
        @(negedge clk);
        rst_n        = 1'b0;
        in_valid     = 1'b1;
        butterfly_in = rand_frame();
        send(rand_frame(), 0);
        rst_n = 1'b1;
        send(rand_frame(), 0);
        idle(4);

        check("drain_pending", due_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
